// File: rtl/alu_reducer.sv
// alu_reducer: folds a stream of big-endian WIDTH_P-bit operands into an accumulator with ADD/MUL/AND/XOR
//   clk_i, rst_i (async, active-high)
//   valid_i, data_i, ready_o : byte stream in, a byte is taken when valid_i && ready_o
//   start_i, op_i, len_i      : begin a reduction of len_i operands with op_i (0 ADD, 1 MUL, 2 AND, 3 XOR)
//   busy_o, done_o, result_o  : activity flag, one-cycle completion pulse, accumulator
module alu_reducer #(
    parameter int WIDTH_P     = 32,
    parameter int LEN_WIDTH_P = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid_i,
    input  logic [7:0]             data_i,
    output logic                   ready_o,
    input  logic                   start_i,
    input  logic [1:0]             op_i,
    input  logic [LEN_WIDTH_P-1:0] len_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [WIDTH_P-1:0]     result_o
);
    localparam int BYTES_L = WIDTH_P / 8;
    localparam int BCW_L   = $clog2(BYTES_L + 1);
    localparam int MCW_L   = $clog2(WIDTH_P);
    localparam logic [1:0] OP_ADD = 2'd0, OP_MUL = 2'd1, OP_AND = 2'd2;

    typedef enum logic [2:0] {IDLE, COLLECT, EXEC, MUL, DONE} state_t;

    state_t                 state_q, state_d;
    logic [WIDTH_P-1:0]     acc_q, opnd_q, mcand_q, mplier_q, part_q;
    logic [BCW_L-1:0]       bcnt_q;
    logic [MCW_L-1:0]       mcnt_q;
    logic [LEN_WIDTH_P-1:0] rem_q;
    logic [1:0]             op_q;

    logic               accept, last_byte, mul_last, cnt_last;
    logic [WIDTH_P-1:0] part_nxt, opnd_shift, identity;

    assign accept     = valid_i && state_q == COLLECT;
    assign last_byte  = accept && bcnt_q == BCW_L'(BYTES_L - 1);
    assign mul_last   = mcnt_q == MCW_L'(WIDTH_P - 1);
    assign cnt_last   = rem_q == LEN_WIDTH_P'(1);
    assign part_nxt   = part_q + (mplier_q[0] ? mcand_q : '0);
    // new byte enters at the LSB end so the first byte ends up in the top byte
    assign opnd_shift = WIDTH_P'({opnd_q, data_i});
    assign identity   = op_i == OP_MUL ? WIDTH_P'(1) : op_i == OP_AND ? '1 : '0;

    assign ready_o  = state_q == COLLECT;
    assign busy_o   = state_q != IDLE;
    assign done_o   = state_q == DONE;
    assign result_o = acc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = len_i != '0 ? COLLECT : DONE;
            COLLECT: if (last_byte) state_d = EXEC;
            EXEC:    state_d = op_q == OP_MUL ? MUL : cnt_last ? DONE : COLLECT;
            MUL:     if (mul_last) state_d = cnt_last ? DONE : COLLECT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            part_q   <= '0;
            bcnt_q   <= '0;
            mcnt_q   <= '0;
            rem_q    <= '0;
            op_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    op_q   <= op_i;
                    rem_q  <= len_i;
                    acc_q  <= identity;
                    bcnt_q <= '0;
                end
                COLLECT: if (accept) begin
                    opnd_q <= opnd_shift;
                    bcnt_q <= bcnt_q + 1'b1;
                end
                EXEC: begin
                    bcnt_q <= '0;
                    if (op_q == OP_MUL) begin
                        mcand_q  <= acc_q;
                        mplier_q <= opnd_q;
                        part_q   <= '0;
                        mcnt_q   <= '0;
                    end else begin
                        acc_q <= op_q == OP_ADD ? acc_q + opnd_q :
                                 op_q == OP_AND ? acc_q & opnd_q : acc_q ^ opnd_q;
                        rem_q <= rem_q - 1'b1;
                    end
                end
                MUL: begin
                    // one shift-add step per cycle; the final step's sum is the truncated product
                    part_q   <= part_nxt;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    mcnt_q   <= mcnt_q + 1'b1;
                    if (mul_last) begin
                        acc_q <= part_nxt;
                        rem_q <= rem_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_reducer.sv
// tb_alu_reducer: directed and randomized reductions checked against an arithmetic reference model
module tb_alu_reducer;
    logic        clk_i = 0;
    logic        rst_i = 1;
    logic        valid_i = 0, start_i = 0, ready_o, busy_o, done_o;
    logic [7:0]  data_i = 0;
    logic [1:0]  op_i = 0;
    logic [15:0] len_i = 0;
    logic [31:0] result_o;
    logic        v16 = 0, s16 = 0, r16, b16, dn16;
    logic [7:0]  d16 = 0;
    logic [1:0]  op16 = 0;
    logic [15:0] len16 = 0;
    logic [15:0] res16;
    int          total = 0, passed = 0;
    logic [31:0] opq[$];

    always #5 clk_i = ~clk_i;

    alu_reducer #(.WIDTH_P(32), .LEN_WIDTH_P(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o),
        .start_i(start_i), .op_i(op_i), .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
        .result_o(result_o));

    alu_reducer #(.WIDTH_P(16), .LEN_WIDTH_P(16)) dut16 (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(v16), .data_i(d16), .ready_o(r16),
        .start_i(s16), .op_i(op16), .len_i(len16), .busy_o(b16), .done_o(dn16),
        .result_o(res16));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] q[$]);
        logic [31:0] a;
        a = op == 1 ? 32'd1 : op == 2 ? 32'hFFFF_FFFF : 32'd0;
        foreach (q[i])
            case (op)
                2'd0:    a = a + q[i];
                2'd1:    a = a * q[i];
                2'd2:    a = a & q[i];
                default: a = a ^ q[i];
            endcase
        return a;
    endfunction

    // while the block is not ready, wiggle junk bytes and stray start pulses at it
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        valid_i = 0;
        repeat ($urandom_range(0, 2)) tick;
        valid_i = 1;
        while (!ready_o && n < 200) begin
            data_i  = 8'($urandom);
            start_i = 1'($urandom_range(0, 1));
            op_i    = 2'($urandom);
            len_i   = 16'($urandom);
            tick;
            n++;
        end
        if (n >= 200) check("ready wait timeout", 1, 0);
        start_i = 0;
        data_i  = b;
        tick;
        valid_i = 0;
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [15:0] len);
        int n = 0;
        logic [31:0] exp;
        exp = model(op, opq);
        valid_i = 1;
        data_i  = 8'($urandom);
        tick;
        valid_i = 0;
        start_i = 1;
        op_i    = op;
        len_i   = len;
        tick;
        start_i = 0;
        foreach (opq[i])
            for (int k = 3; k >= 0; k--) send_byte(opq[i][8*k +: 8]);
        while (!done_o && n < 200) begin
            tick;
            n++;
        end
        check({tag, " latency"}, 64'(n), len == 0 ? 0 : op == 1 ? 33 : 1);
        check({tag, " result"}, result_o, exp);
        start_i = 1;
        op_i    = 2'd0;
        len_i   = 16'd1;
        tick;
        start_i = 0;
        check({tag, " single done/start ignored"}, {done_o, busy_o}, 0);
        check({tag, " result held"}, result_o, exp);
    endtask

    initial begin
        int n;
        logic seen;
        logic [7:0] b16[4];
        #1;
        check("reset ctrl", {ready_o, busy_o, done_o}, 0);
        check("reset result", result_o, 0);
        tick;
        rst_i = 0;
        tick;

        opq = '{32'h2, 32'h3, 32'h7};
        run("mul chain", 2'd1, 16'd3);
        opq = '{32'hFFFF_FFFF, 32'h2};
        run("add wrap", 2'd0, 16'd2);
        opq = {};
        run("zero len mul", 2'd1, 16'd0);
        run("zero len and", 2'd2, 16'd0);
        opq = '{32'h1234_5678, 32'hFF00_FF00};
        check("xor model", model(2'd3, opq), 32'hED34_A978);
        run("xor gaps", 2'd3, 16'd2);

        for (int r = 0; r < 8; r++) begin
            logic [1:0] op;
            int len;
            op  = 2'($urandom_range(0, 3));
            len = $urandom_range(0, 3);
            opq = {};
            repeat (len) opq.push_back(op == 2 ? ($urandom | $urandom) : $urandom);
            run($sformatf("rand%0d op%0d", r, op), op, 16'(len));
        end

        start_i = 1;
        op_i    = 2'd1;
        len_i   = 16'd2;
        tick;
        start_i = 0;
        for (int k = 3; k >= 0; k--) send_byte(8'(32'h3 >> (8*k)));
        repeat (10) tick;
        #2 rst_i = 1;
        #1;
        check("async reset ctrl", {ready_o, busy_o, done_o}, 0);
        check("async reset result", result_o, 0);
        tick;
        rst_i = 0;
        seen = 0;
        repeat (40) begin
            tick;
            seen |= done_o | busy_o;
        end
        check("no done after reset", seen, 0);
        opq = '{32'h5};
        run("add after reset", 2'd0, 16'd1);

        b16 = '{8'h01, 8'h00, 8'h01, 8'h00};
        s16   = 1;
        op16  = 2'd1;
        len16 = 16'd2;
        tick;
        s16 = 0;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            v16 = 1;
            d16 = b16[i];
            while (!r16 && n < 200) begin
                tick;
                n++;
            end
            if (n >= 200) check("w16 ready timeout", 1, 0);
            tick;
            v16 = 0;
        end
        n = 0;
        while (!dn16 && n < 200) begin
            tick;
            n++;
        end
        check("w16 latency", 64'(n), 17);
        check("w16 result", res16, 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_reducer.md
Name: alu_reducer

Overview:
- Parametrised stream-reduction engine for the UART ALU datapath.
- Assembles big-endian operands of WIDTH_P bits from the UART byte stream.
- Folds a count of len_i operands into an accumulator using one of four operations: ADD, MUL, AND, XOR.
- Contains its own iterative shift-add multiplier, so it needs no external multiplier instance; it reports completion to the ALU top level.

Parameters:
- WIDTH_P, 32, operand and result width in bits; must be a multiple of 8 and at least 8.
- LEN_WIDTH_P, 16, width of the operand-count input.

Ports:
- clk_i  input  1  clock; the only clock domain.
- rst_i  input  1  reset, asynchronous, active-high.
- valid_i  input  1  data_i carries a byte this cycle.
- data_i  input  8  payload byte, MSB-first within each operand.
- ready_o  output  1  block accepts a byte this cycle; a byte is taken only when valid_i && ready_o.
- start_i  input  1  begin a reduction; sampled only in IDLE.
- op_i  input  2  operation: 0 ADD, 1 MUL, 2 AND, 3 XOR; latched on start.
- len_i  input  LEN_WIDTH_P  number of operands; latched on start.
- busy_o  output  1  high in every state except IDLE.
- done_o  output  1  one-cycle completion pulse.
- result_o  output  WIDTH_P  accumulator value.

Behaviour:
- Reset: all state is cleared asynchronously when rst_i is high.
  - State goes to IDLE; accumulator to 0; byte counter, operand count, shift registers and latched op to 0.
  - Outputs: ready_o=0, busy_o=0, done_o=0, result_o=0.
  - Reset in any state, including mid-multiply, abandons the operation with no done_o pulse.
- States: IDLE, COLLECT, EXEC, MUL, DONE.
- IDLE:
  - ready_o=0; result_o holds the last result.
  - On start_i: latch op_i and len_i; load accumulator with the op's identity (ADD/XOR 0, MUL 1, AND all-ones); clear the byte counter.
  - Next state is COLLECT if len_i!=0, else DONE.
  - Bytes presented in IDLE are not consumed.
- COLLECT:
  - ready_o=1.
  - Each accepted byte shifts into the operand register from the LSB end, so the first byte ends in bits [WIDTH_P-1:WIDTH_P-8].
  - When the (WIDTH_P/8)-th byte is accepted, go to EXEC next cycle.
- EXEC (1 cycle, ready_o=0):
  - ADD: acc = (acc + operand) mod 2^WIDTH_P, carry discarded.
  - AND / XOR: bitwise on acc and operand.
  - For ADD, AND and XOR: decrement the remaining count; go to DONE if it reaches 0, else COLLECT with the byte counter cleared.
  - MUL: load multiplicand=acc, multiplier=operand, partial=0; go to MUL.
- MUL (ready_o=0): exactly WIDTH_P cycles.
  - Each cycle: if multiplier LSB is set, partial += multiplicand; then multiplicand <<= 1 and multiplier >>= 1. All registers are WIDTH_P bits.
  - Result is the low WIDTH_P bits of the unsigned product.
  - On the last cycle: acc = final partial; decrement the count; go to DONE or COLLECT.
- DONE:
  - done_o=1 for exactly this one cycle; next state is IDLE.
  - start_i asserted in DONE is ignored.
- result_o is driven by the accumulator at all times. It is only meaningful when done_o=1 or in IDLE after a completed run; it is stable from DONE until the next start.
- Latency, counted from the cycle the last byte of an operand is accepted:
  - ADD/AND/XOR: accumulator updated 1 cycle later.
  - MUL: accumulator updated WIDTH_P+1 cycles later.
  - DONE follows on the next cycle.
  - len_i=0: done_o asserts 1 cycle after the start cycle, with result_o = identity.
- start_i while busy_o=1 is ignored; latched op and len are unchanged.
- Counter width: the remaining-operand count is LEN_WIDTH_P bits. len_i=2^LEN_WIDTH_P-1 must complete without wrap.

Test Plan:
- MUL chain: WIDTH_P=32, op=1, len=3, operands 0x00000002, 0x00000003, 0x00000007 → one done_o pulse, result_o=0x0000002A. Exactly 32 MUL cycles per operand between EXEC and the next ready_o=1.
- ADD wrap: op=0, len=2, operands 0xFFFFFFFF, 0x00000002 → result_o=0x00000001. The accumulator updates one cycle after the 4th byte of the second operand is accepted.
- Zero length: op=1, len=0, start_i pulse → done_o high one cycle after start, result_o=0x00000001. op=2, len=0 → result_o=0xFFFFFFFF.
- Handshake gaps:
  - op=3, len=2, operands 0x12345678, 0xFF00FF00, with valid_i deasserted randomly between bytes → result_o=0xED34A978.
  - Bytes driven during EXEC/MUL/IDLE (ready_o=0) are not consumed.
  - start_i pulsed mid-run changes nothing.
- Reset mid-operation: assert rst_i asynchronously during MUL cycle 10 → immediately state IDLE, result_o=0, busy_o=0, no done_o. A following ADD run with len=1, operand 0x00000005 → result_o=0x00000005.
- Width variant: WIDTH_P=16 build, op=1, len=2, operands 0x0100, 0x0100 → result_o=0x0000 (product truncated). The MUL phase lasts 16 cycles per operand.
